data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter MEM_BYTES, default 4096: data RAM size in bytes; power of two.
REQ-002 Parameter FIFO_DEPTH, default 8: console FIFO entries; power of two, at least 2.
REQ-003 Parameter IO_BASE, default 64'hFFFF_FFFF_FFFF_FF00: base address of the I/O register window.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 AddressBus  in  64  byte address driven by the CPU.
REQ-007 DataBusOut  in  64  CPU store data.
REQ-008 ControlBus  in  3  {MemWriteEn, MemReadEn, RegWriteEn}; bit 0 ignored.
REQ-009 DataBusIn  out  64  load data returned to the CPU.
REQ-010 cons_data  out  8  console byte at the FIFO head.
REQ-011 cons_valid  out  1  FIFO non-empty.
REQ-012 cons_ready  in  1  console sink accepts the head byte.

Function
REQ-013 Decode: address below MEM_BYTES selects RAM; IO_BASE+0x00 selects TXDATA, +0x08 STATUS, +0x10 CYCLE; any other address is unmapped.
REQ-014 RAM is byte-addressed little-endian; an access covers 8 bytes at addr[log2(MEM_BYTES)-1:0]+0..7, with byte indices wrapping modulo MEM_BYTES.
REQ-015 Reads are combinational: when MemReadEn=1, DataBusIn carries the selected data in the same cycle.
REQ-016 When MemReadEn=0, or on an unmapped or TXDATA read, DataBusIn SHALL be 0.
REQ-017 RAM writes occur on the posedge where MemWriteEn=1, and all 8 bytes are written.
REQ-018 If MemReadEn=1 and MemWriteEn=1 together, the read returns pre-write data and the write commits at the edge.
REQ-019 Writes to unmapped addresses, CYCLE, or RAM during rst=1 have no effect.
REQ-020 A TXDATA write pushes DataBusOut[7:0] into the console FIFO at the edge.
REQ-021 A pushed byte appears on cons_data with cons_valid=1 in the cycle after the push edge (first-word fall-through).
REQ-022 A pop occurs on a posedge where cons_valid=1 and cons_ready=1; the next entry is presented in the following cycle.
REQ-023 Push while full with no pop in the same cycle: the byte is dropped and sticky overflow is set to 1.
REQ-024 Push and pop in the same cycle while full: both succeed, the count is unchanged, and overflow is not set.
REQ-025 Push and pop in the same cycle while count=1: the new byte becomes the head and the count stays 1.
REQ-026 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-027 STATUS read value = {zeros, overflow[bit 17], full[bit 16], empty[bit 15], zeros[14:8], count[7:0]}.
REQ-028 A STATUS write with DataBusOut[17]=1 clears overflow; if that write coincides with a new overflow event, the set wins.
REQ-029 CYCLE is a 64-bit free-running counter incremented every non-reset edge; it wraps from all-ones to 0 and reads return its current value.
REQ-030 cons_data is undefined-but-stable (held last value) when cons_valid=0; the sink must ignore it.

Reset
REQ-031 On a rst=1 edge: the FIFO is emptied (count=0, pointers=0), overflow=0, CYCLE=0, and cons_data=0.
REQ-032 cons_valid is low in the cycle after the reset edge, including when reset arrives while bytes are queued or a pop is in progress.
REQ-033 RAM contents are not cleared by reset; they are zero at time 0.
REQ-034 While rst=1, DataBusIn=0 and no push or pop takes effect.

Structure
REQ-035 A shared package holds: the I/O offsets (TXDATA, STATUS, CYCLE), the ControlBus bit indices, and the STATUS bit positions.
REQ-036 The console FIFO is a sub-module sync_fifo with push/pop/full/empty/count ports and the same clk/rst.
REQ-037 RAM, address decode, STATUS/CYCLE registers and the read mux live in the top level.

Verification
REQ-038 sd 0x1122334455667788 to RAM 0x10, then ld 0x10 in the next cycle -> 0x1122334455667788; lb-view byte 0x10 = 0x88.
REQ-039 Access at 0xFFC with MEM_BYTES=4096 -> bytes land at 0xFFC..0xFFF and 0x000..0x003; read-back matches.
REQ-040 Push 9 bytes 0x41..0x49 with cons_ready=0 (depth 8) -> STATUS reads count=8, full=1, overflow=1; draining yields 0x41..0x48 in order.
REQ-041 With FIFO full, push 0x5A while popping -> count stays 8, overflow stays 0, and 0x5A is the last byte drained.
REQ-042 Assert rst for 1 cycle with 3 bytes queued -> cons_valid=0 and CYCLE=0 next cycle; RAM data written before reset is still readable.
REQ-043 Simultaneous read+write of RAM 0x20 (old 0x0, new 0xAB) -> same-cycle DataBusIn=0x0; next-cycle read returns 0xAB.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data bus responder: I/O register offsets, ControlBus bit
// indices, STATUS field positions and the address-decode select type.
package data_bus_responder_pkg;

    localparam logic [7:0] TXDATA_OFF = 8'h00;
    localparam logic [7:0] STATUS_OFF = 8'h08;
    localparam logic [7:0] CYCLE_OFF  = 8'h10;

    localparam int unsigned CTRL_MEM_WRITE = 2;
    localparam int unsigned CTRL_MEM_READ  = 1;
    localparam int unsigned CTRL_REG_WRITE = 0;

    localparam int unsigned STAT_OVERFLOW_BIT = 17;
    localparam int unsigned STAT_FULL_BIT     = 16;
    localparam int unsigned STAT_EMPTY_BIT    = 15;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelTxdata,
        SelStatus,
        SelCycle
    } bus_sel_e;

    function automatic logic [63:0] status_word(input logic       overflow,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] count);
        logic [63:0] w;
        w                    = '0;
        w[STAT_OVERFLOW_BIT] = overflow;
        w[STAT_FULL_BIT]     = full;
        w[STAT_EMPTY_BIT]    = empty;
        w[7:0]               = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with a registered head output that holds its last value
// while empty. Push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = head_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
        // Look ahead to next cycle's head; bypass the byte being written if it lands there.
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
            else                                  head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-bus slave: byte-addressed little-endian RAM plus an I/O window holding a
// console TX FIFO, a STATUS register and a free-running cycle counter.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [63:0] IO_BASE    = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] AddressBus,
    input  logic [63:0] DataBusOut,
    input  logic [2:0]  ControlBus,
    output logic [63:0] DataBusIn,
    output logic [7:0]  cons_data,
    output logic        cons_valid,
    input  logic        cons_ready
);

    localparam int unsigned MAW = $clog2(MEM_BYTES);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    logic           mem_we, mem_re;
    logic           unused_reg_we;
    bus_sel_e       sel;
    logic [MAW-1:0] ram_off;
    logic [63:0]    ram_rdata;

    // Power-up contents are zero; reset deliberately leaves the array alone.
    logic [7:0]     ram_q [MEM_BYTES];

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           overflow_q, overflow_d, overflow_set, overflow_clr;
    logic [63:0]    cycle_q;

    assign mem_we        = ControlBus[CTRL_MEM_WRITE];
    assign mem_re        = ControlBus[CTRL_MEM_READ];
    assign unused_reg_we = ControlBus[CTRL_REG_WRITE];
    assign ram_off       = AddressBus[MAW-1:0];

    always_comb begin
        sel = SelNone;
        if (AddressBus < 64'(MEM_BYTES))                   sel = SelRam;
        else if (AddressBus == IO_BASE + 64'(TXDATA_OFF)) sel = SelTxdata;
        else if (AddressBus == IO_BASE + 64'(STATUS_OFF)) sel = SelStatus;
        else if (AddressBus == IO_BASE + 64'(CYCLE_OFF))  sel = SelCycle;
    end

    // Byte indices wrap modulo MEM_BYTES through the MAW-bit addition.
    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            ram_rdata[8*i +: 8] = ram_q[MAW'(ram_off + MAW'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we && (sel == SelRam)) begin
            for (int i = 0; i < 8; i++) begin
                ram_q[MAW'(ram_off + MAW'(i))] <= DataBusOut[8*i +: 8];
            end
        end
    end

    assign fifo_push  = !rst && mem_we && (sel == SelTxdata);
    assign fifo_pop   = !rst && cons_valid && cons_ready;
    assign cons_valid = !fifo_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_cons_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (DataBusOut[7:0]),
        .pop       (fifo_pop),
        .pop_data  (cons_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A dropped push outranks a concurrent software clear.
    assign overflow_set = fifo_push && fifo_full && !fifo_pop;
    assign overflow_clr = !rst && mem_we && (sel == SelStatus) && DataBusOut[STAT_OVERFLOW_BIT];

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_set)      overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            cycle_q    <= cycle_q + 64'd1;
        end
    end

    always_comb begin
        DataBusIn = '0;
        if (!rst && mem_re) begin
            unique case (sel)
                SelRam:    DataBusIn = ram_rdata;
                SelStatus: DataBusIn = status_word(overflow_q, fifo_full, fifo_empty,
                                                   8'(fifo_count));
                SelCycle:  DataBusIn = cycle_q;
                default:   DataBusIn = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder: RAM, decode, console FIFO,
// STATUS/overflow, CYCLE and reset behaviour with hand-computed expectations.
module tb_data_bus_responder;

    localparam logic [63:0] IO     = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] TX     = IO + 64'h00;
    localparam logic [63:0] STAT   = IO + 64'h08;
    localparam logic [63:0] CYC    = IO + 64'h10;
    localparam logic [2:0]  IDLE   = 3'b000;
    localparam logic [2:0]  RD     = 3'b010;
    localparam logic [2:0]  WR     = 3'b100;
    localparam logic [2:0]  RW     = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] AddressBus;
    logic [63:0] DataBusOut;
    logic [2:0]  ControlBus;
    logic [63:0] DataBusIn;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_bus_responder #(
        .MEM_BYTES  (4096),
        .FIFO_DEPTH (8),
        .IO_BASE    (IO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .AddressBus (AddressBus),
        .DataBusOut (DataBusOut),
        .ControlBus (ControlBus),
        .DataBusIn  (DataBusIn),
        .cons_data  (cons_data),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready)
    );

    // Drive one bus cycle at the falling edge; it commits on the following rising edge.
    task automatic drive(input logic [2:0] ctrl, input logic [63:0] addr,
                         input logic [63:0] data, input logic rdy);
        @(negedge clk);
        ControlBus = ctrl;
        AddressBus = addr;
        DataBusOut = data;
        cons_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cons_ready = 1'b0;
        ControlBus = IDLE;
        AddressBus = '0;
        DataBusOut = '0;
        repeat (2) @(posedge clk);
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_read_zero: got %h want %h", DataBusIn, 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        ControlBus = RD;
        AddressBus = CYC;
        #1;
        n_cmp++;
        if (DataBusIn !== 64'h0 || cons_valid !== 1'b0 || cons_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: cycle=%h valid=%b data=%h want 0/0/00",
                     DataBusIn, cons_valid, cons_data);
        end
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h8000) begin
            n_bad++;
            $display("FAIL reset_status: got %h want %h", DataBusIn, 64'h8000);
        end
        drive(RD, CYC, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'd2) begin
            n_bad++;
            $display("FAIL cycle_count: got %h want %h", DataBusIn, 64'd2);
        end
    endtask

    task automatic test_ram();
        drive(WR, 64'h10, 64'h1122334455667788, 1'b0);
        drive(RD, 64'h10, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h1122334455667788) begin
            n_bad++;
            $display("FAIL ram_ld: got %h want %h", DataBusIn, 64'h1122334455667788);
        end
        n_cmp++;
        if (DataBusIn[7:0] !== 8'h88) begin
            n_bad++;
            $display("FAIL ram_lb: got %h want %h", DataBusIn[7:0], 8'h88);
        end
        drive(RD, 64'h11, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0011223344556677) begin
            n_bad++;
            $display("FAIL ram_unaligned: got %h want %h", DataBusIn, 64'h0011223344556677);
        end
        drive(IDLE, 64'h10, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL read_disabled: got %h want %h", DataBusIn, 64'h0);
        end
    endtask

    task automatic test_wrap();
        drive(WR, 64'hFFC, 64'h0807060504030201, 1'b0);
        drive(RD, 64'hFFC, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0807060504030201) begin
            n_bad++;
            $display("FAIL wrap_readback: got %h want %h", DataBusIn, 64'h0807060504030201);
        end
        drive(RD, 64'h0, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0000000008070605) begin
            n_bad++;
            $display("FAIL wrap_low_bytes: got %h want %h", DataBusIn, 64'h0000000008070605);
        end
    endtask

    task automatic test_decode();
        // 0x2000 aliases RAM offset 0 if the decode were ignored.
        drive(RW, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL unmapped_read: got %h want %h", DataBusIn, 64'h0);
        end
        drive(RD, 64'h0, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0000000008070605) begin
            n_bad++;
            $display("FAIL unmapped_write: got %h want %h", DataBusIn, 64'h0000000008070605);
        end
        drive(RD, TX, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL txdata_read: got %h want %h", DataBusIn, 64'h0);
        end
        drive(RD, IO + 64'h18, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL io_hole_read: got %h want %h", DataBusIn, 64'h0);
        end
    endtask

    task automatic test_rw_same();
        drive(RW, 64'h20, 64'hAB, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL rw_old_data: got %h want %h", DataBusIn, 64'h0);
        end
        drive(RD, 64'h20, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'hAB) begin
            n_bad++;
            $display("FAIL rw_new_data: got %h want %h", DataBusIn, 64'hAB);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            drive(WR, TX, 64'(8'h41 + i), 1'b0);
            if (i == 1) begin
                n_cmp++;
                if (cons_valid !== 1'b1 || cons_data !== 8'h41) begin
                    n_bad++;
                    $display("FAIL fwft_head: valid=%b data=%h want 1/41", cons_valid, cons_data);
                end
            end
        end
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h30008) begin
            n_bad++;
            $display("FAIL overflow_status: got %h want %h", DataBusIn, 64'h30008);
        end
        for (int i = 0; i < 8; i++) begin
            drive(IDLE, 64'h0, 64'h0, 1'b1);
            n_cmp++;
            if (cons_valid !== 1'b1 || cons_data !== 8'(8'h41 + i)) begin
                n_bad++;
                $display("FAIL drain_%0d: valid=%b data=%h want 1/%h",
                         i, cons_valid, cons_data, 8'(8'h41 + i));
            end
        end
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (cons_valid !== 1'b0 || DataBusIn !== 64'h28000) begin
            n_bad++;
            $display("FAIL drained_status: valid=%b status=%h want 0/%h",
                     cons_valid, DataBusIn, 64'h28000);
        end
        drive(WR, STAT, 64'h20000, 1'b0);
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h8000) begin
            n_bad++;
            $display("FAIL overflow_clear: got %h want %h", DataBusIn, 64'h8000);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) drive(WR, TX, 64'(8'h50 + i), 1'b0);
        drive(WR, TX, 64'h5A, 1'b1);
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h10008) begin
            n_bad++;
            $display("FAIL full_push_pop_status: got %h want %h", DataBusIn, 64'h10008);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'h5A : 8'(8'h51 + i);
            drive(IDLE, 64'h0, 64'h0, 1'b1);
            n_cmp++;
            if (cons_valid !== 1'b1 || cons_data !== exp) begin
                n_bad++;
                $display("FAIL full_drain_%0d: valid=%b data=%h want 1/%h",
                         i, cons_valid, cons_data, exp);
            end
        end
        drive(IDLE, 64'h0, 64'h0, 1'b0);
        n_cmp++;
        if (cons_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drain_empty: valid=%b want 0", cons_valid);
        end
    endtask

    task automatic test_count_one();
        drive(WR, TX, 64'h61, 1'b0);
        drive(WR, TX, 64'h62, 1'b1);
        drive(RD, STAT, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'h1 || cons_data !== 8'h62 || cons_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL count1_push_pop: status=%h data=%h valid=%b want 1/62/1",
                     DataBusIn, cons_data, cons_valid);
        end
        drive(IDLE, 64'h0, 64'h0, 1'b1);
        drive(IDLE, 64'h0, 64'h0, 1'b0);
        n_cmp++;
        if (cons_valid !== 1'b0 || cons_data !== 8'h62) begin
            n_bad++;
            $display("FAIL count1_drain: valid=%b data=%h want 0/62", cons_valid, cons_data);
        end
    endtask

    task automatic test_reset_queued();
        drive(WR, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        for (int i = 0; i < 3; i++) drive(WR, TX, 64'(8'h71 + i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cons_ready = 1'b1;
        ControlBus = IDLE;
        @(negedge clk);
        rst = 1'b0;
        cons_ready = 1'b0;
        ControlBus = RD;
        AddressBus = CYC;
        #1;
        n_cmp++;
        if (cons_valid !== 1'b0 || cons_data !== 8'h00 || DataBusIn !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_queued: valid=%b data=%h cycle=%h want 0/00/0",
                     cons_valid, cons_data, DataBusIn);
        end
        drive(RD, 64'h40, 64'h0, 1'b0);
        n_cmp++;
        if (DataBusIn !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_bad++;
            $display("FAIL ram_survives_reset: got %h want %h",
                     DataBusIn, 64'hDEAD_BEEF_CAFE_F00D);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_wrap();
        test_decode();
        test_rw_same();
        test_overflow();
        test_full_push_pop();
        test_count_one();
        test_reset_queued();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
